// File: rtl/mux_scan_n.sv
// Registered N-channel, W-bit multiplexer with manual select and a masked
// auto-scan pointer that dwells a programmable number of cycles per channel.
module mux_scan_n #(
   parameter int NUM_CH = 16,
   parameter int DATA_W = 8,
   parameter int SEL_W  = 4,
   parameter int DWELL  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel_in,
   input  logic                     load,
   input  logic [NUM_CH-1:0]        ch_mask,
   input  logic [NUM_CH*DATA_W-1:0] d,
   output logic [DATA_W-1:0]        y,
   output logic [SEL_W-1:0]         ch_out,
   output logic                     valid,
   output logic                     wrap
);

   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

   logic [SEL_W-1:0]  ptr;
   logic [CNT_W-1:0]  dwell_cnt;
   logic              sel_ok;
   logic [DATA_W-1:0] sel_data;
   logic [DATA_W-1:0] ptr_data;
   logic              sel_bit;
   logic              ptr_bit;
   logic              hi_found;
   logic              lo_found;
   logic [SEL_W-1:0]  hi_idx;
   logic [SEL_W-1:0]  lo_idx;

   assign sel_ok = 32'(sel_in) < 32'(NUM_CH);

   // Loop-based selection keeps out-of-range indices from ever addressing d.
   always_comb begin
      sel_data = '0;
      ptr_data = '0;
      sel_bit  = 1'b0;
      ptr_bit  = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (sel_in == SEL_W'(k)) begin
            sel_data = d[k*DATA_W +: DATA_W];
            sel_bit  = ch_mask[k];
         end
         if (ptr == SEL_W'(k)) begin
            ptr_data = d[k*DATA_W +: DATA_W];
            ptr_bit  = ch_mask[k];
         end
      end
   end

   // Downward scan: the last hit is the lowest qualifying index.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (ch_mask[k]) begin
            lo_found = 1'b1;
            lo_idx   = SEL_W'(k);
            if (SEL_W'(k) > ptr) begin
               hi_found = 1'b1;
               hi_idx   = SEL_W'(k);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y         <= '0;
         ch_out    <= '0;
         valid     <= 1'b0;
         wrap      <= 1'b0;
         ptr       <= '0;
         dwell_cnt <= '0;
      end else if (!en) begin
         wrap <= 1'b0;
      end else if (!mode) begin
         ch_out    <= sel_in;
         dwell_cnt <= '0;
         wrap      <= 1'b0;
         if (sel_ok) begin
            y     <= sel_data;
            valid <= sel_bit;
            ptr   <= sel_in;
         end else begin
            y     <= '0;
            valid <= 1'b0;
         end
      end else begin
         y      <= ptr_data;
         ch_out <= ptr;
         valid  <= ptr_bit;
         wrap   <= 1'b0;
         if (load && sel_ok) begin
            ptr       <= sel_in;
            dwell_cnt <= '0;
         end else if (dwell_cnt == CNT_LAST) begin
            dwell_cnt <= '0;
            if (hi_found) begin
               ptr <= hi_idx;
            end else if (lo_found) begin
               ptr  <= lo_idx;
               wrap <= 1'b1;
            end
         end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: three instances (16ch/dwell1, 16ch/dwell3, 12ch/dwell2)
// share stimulus and are compared with a list-based scan model.
module tb_mux_scan_n;

   logic        clk;
   logic        rst;
   logic        en;
   logic        mode;
   logic [3:0]  sel;
   logic        load;
   logic [15:0] mask;
   logic [7:0]  dat [16];
   logic [127:0] d16;
   logic [95:0]  d12;

   logic [7:0] y_o   [3];
   logic [3:0] ch_o  [3];
   logic       val_o [3];
   logic       wrap_o[3];

   int nch [3] = '{16, 16, 12};
   int dwl [3] = '{1, 3, 2};

   int         m_ptr [3];
   int         m_cnt [3];
   logic [7:0] m_y   [3];
   int         m_ch  [3];
   logic       m_val [3];
   logic       m_wrap[3];

   int checks = 0;
   int errors = 0;

   always_comb begin
      d16 = '0;
      for (int k = 0; k < 16; k++) d16[k*8 +: 8] = dat[k];
   end
   assign d12 = d16[95:0];

   mux_scan_n #(.NUM_CH(16), .DATA_W(8), .SEL_W(4), .DWELL(1)) dut_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel), .load(load),
      .ch_mask(mask), .d(d16), .y(y_o[0]), .ch_out(ch_o[0]), .valid(val_o[0]), .wrap(wrap_o[0]));
   mux_scan_n #(.NUM_CH(16), .DATA_W(8), .SEL_W(4), .DWELL(3)) dut_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel), .load(load),
      .ch_mask(mask), .d(d16), .y(y_o[1]), .ch_out(ch_o[1]), .valid(val_o[1]), .wrap(wrap_o[1]));
   mux_scan_n #(.NUM_CH(12), .DATA_W(8), .SEL_W(4), .DWELL(2)) dut_c (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel), .load(load),
      .ch_mask(mask[11:0]), .d(d12), .y(y_o[2]), .ch_out(ch_o[2]), .valid(val_o[2]), .wrap(wrap_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_ptr[i] = 0; m_cnt[i] = 0; m_y[i] = 8'h00;
         m_ch[i] = 0; m_val[i] = 1'b0; m_wrap[i] = 1'b0;
      end
   endtask

   // Scan order is the sorted list of enabled channels; advancing takes the
   // first entry above the pointer, else the head of the list (a wrap).
   task automatic model_step();
      int s;
      int nxt;
      int on[$];
      s = int'(sel);
      for (int i = 0; i < 3; i++) begin
         m_wrap[i] = 1'b0;
         if (!en) continue;
         if (!mode) begin
            m_ch[i] = s;
            m_cnt[i] = 0;
            if (s < nch[i]) begin
               m_y[i] = dat[s]; m_val[i] = mask[s]; m_ptr[i] = s;
            end else begin
               m_y[i] = 8'h00; m_val[i] = 1'b0;
            end
         end else begin
            m_y[i] = dat[m_ptr[i]];
            m_ch[i] = m_ptr[i];
            m_val[i] = mask[m_ptr[i]];
            if (load && s < nch[i]) begin
               m_ptr[i] = s; m_cnt[i] = 0;
            end else if (m_cnt[i] + 1 == dwl[i]) begin
               m_cnt[i] = 0;
               on.delete();
               for (int k = 0; k < nch[i]; k++) if (mask[k]) on.push_back(k);
               if (on.size() > 0) begin
                  nxt = -1;
                  foreach (on[j]) if (nxt < 0 && on[j] > m_ptr[i]) nxt = on[j];
                  if (nxt < 0) begin
                     nxt = on[0];
                     m_wrap[i] = 1'b1;
                  end
                  m_ptr[i] = nxt;
               end
            end else begin
               m_cnt[i] = m_cnt[i] + 1;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
   endtask

   task automatic test_reset();
      en = 1'b1; mode = 1'b0; load = 1'b0; mask = 16'hFFFF;
      for (int k = 0; k < 16; k++) dat[k] = 8'h10 + 8'(k);
      rst = 1'b0;
      for (int s = 3; s < 7; s++) begin sel = 4'(s); tick(); end
      #2 rst = 1'b1;
      model_reset();
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (y_o[i] !== 8'h00 || ch_o[i] !== 4'h0 || val_o[i] !== 1'b0 || wrap_o[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset inst%0d y=%h ch=%0d valid=%b wrap=%b required 00/0/0/0",
                     i, y_o[i], ch_o[i], val_o[i], wrap_o[i]);
         end
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_manual();
      mode = 1'b0; mask = 16'hFFFF;
      for (int s = 0; s < 16; s++) begin
         sel = 4'(s);
         tick();
         checks++;
         if (y_o[0] !== 8'h10 + 8'(s) || ch_o[0] !== 4'(s) || val_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL manual sel=%0d y=%h ch=%0d valid=%b required %h/%0d/1",
                     s, y_o[0], ch_o[0], val_o[0], 8'h10 + 8'(s), s);
         end
         checks++;
         if (y_o[2] !== m_y[2] || ch_o[2] !== 4'(m_ch[2]) || val_o[2] !== m_val[2]) begin
            errors++;
            $display("FAIL manual12 sel=%0d y=%h/%h ch=%0d/%0d valid=%b/%b",
                     s, y_o[2], m_y[2], ch_o[2], m_ch[2], val_o[2], m_val[2]);
         end
      end
   endtask

   task automatic test_auto_wrap();
      mode = 1'b0; sel = 4'd0; tick();
      mode = 1'b1; mask = 16'h0005;
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if (ch_o[0] !== 4'(2 * (c % 2)) || wrap_o[0] !== 1'(c % 2)) begin
            errors++;
            $display("FAIL auto_wrap cyc=%0d ch=%0d wrap=%b required %0d/%0d",
                     c, ch_o[0], wrap_o[0], 2 * (c % 2), c % 2);
         end
      end
   endtask

   task automatic test_dwell();
      mode = 1'b0; sel = 4'd0; tick();
      mode = 1'b1; mask = 16'h0003;
      for (int c = 0; c < 12; c++) begin
         tick();
         checks++;
         if (ch_o[1] !== 4'((c / 3) % 2) || wrap_o[1] !== 1'(c % 6 == 5)) begin
            errors++;
            $display("FAIL dwell cyc=%0d ch=%0d wrap=%b required %0d/%0d",
                     c, ch_o[1], wrap_o[1], (c / 3) % 2, c % 6 == 5);
         end
      end
   endtask

   task automatic test_load_enable_range();
      mode = 1'b0; sel = 4'd0; tick();
      mode = 1'b1; mask = 16'hFFFF; tick();
      load = 1'b1; sel = 4'd9; tick();
      load = 1'b0; sel = 4'd2;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (ch_o[1] !== 4'd9 || y_o[1] !== dat[9]) begin
            errors++;
            $display("FAIL load cyc=%0d ch=%0d y=%h required 9/%h", c, ch_o[1], y_o[1], dat[9]);
         end
      end
      en = 1'b0; sel = 4'd5; load = 1'b1;
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 16; k++) dat[k] = 8'($urandom);
         tick();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (y_o[i] !== m_y[i] || ch_o[i] !== 4'(m_ch[i]) || val_o[i] !== m_val[i] || wrap_o[i] !== 1'b0) begin
               errors++;
               $display("FAIL freeze inst%0d y=%h/%h ch=%0d/%0d valid=%b/%b wrap=%b/0",
                        i, y_o[i], m_y[i], ch_o[i], m_ch[i], val_o[i], m_val[i], wrap_o[i]);
            end
         end
      end
      en = 1'b1; load = 1'b0; mode = 1'b0; sel = 4'hF;
      tick();
      checks++;
      if (y_o[2] !== 8'h00 || val_o[2] !== 1'b0 || ch_o[2] !== 4'hF) begin
         errors++;
         $display("FAIL range y=%h valid=%b ch=%0d required 00/0/15", y_o[2], val_o[2], ch_o[2]);
      end
   endtask

   task automatic test_masks();
      int ch0;
      mode = 1'b0; sel = 4'd4; tick();
      mode = 1'b1; mask = 16'h0000;
      ch0 = 4;
      for (int c = 0; c < 8; c++) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (val_o[i] !== 1'b0 || wrap_o[i] !== 1'b0 || ch_o[i] !== 4'(ch0)) begin
               errors++;
               $display("FAIL mask0 inst%0d valid=%b wrap=%b ch=%0d required 0/0/%0d",
                        i, val_o[i], wrap_o[i], ch_o[i], ch0);
            end
         end
      end
      mask = 16'h8000;
      for (int c = 0; c < 12; c++) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (y_o[i] !== m_y[i] || ch_o[i] !== 4'(m_ch[i]) || val_o[i] !== m_val[i] || wrap_o[i] !== m_wrap[i]) begin
               errors++;
               $display("FAIL mask8000 inst%0d cyc=%0d y=%h/%h ch=%0d/%0d valid=%b/%b wrap=%b/%b",
                        i, c, y_o[i], m_y[i], ch_o[i], m_ch[i], val_o[i], m_val[i], wrap_o[i], m_wrap[i]);
            end
         end
      end
      checks++;
      if (ch_o[0] !== 4'd15 || wrap_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL single_ch ch=%0d wrap=%b required 15/1", ch_o[0], wrap_o[0]);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst  = ($urandom_range(0, 59) == 0);
         en   = ($urandom_range(0, 7) != 0);
         mode = ($urandom_range(0, 5) != 0);
         load = ($urandom_range(0, 9) == 0);
         sel  = 4'($urandom);
         if ($urandom_range(0, 15) == 0) mask = 16'($urandom) & 16'($urandom);
         for (int k = 0; k < 16; k++) dat[k] = 8'($urandom);
         tick();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (y_o[i] !== m_y[i] || ch_o[i] !== 4'(m_ch[i]) || val_o[i] !== m_val[i] || wrap_o[i] !== m_wrap[i]) begin
               errors++;
               $display("FAIL random inst%0d cyc=%0d y=%h/%h ch=%0d/%0d valid=%b/%b wrap=%b/%b",
                        i, c, y_o[i], m_y[i], ch_o[i], m_ch[i], val_o[i], m_val[i], wrap_o[i], m_wrap[i]);
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 4'd0; load = 1'b0; mask = 16'hFFFF;
      for (int k = 0; k < 16; k++) dat[k] = 8'h00;
      model_reset();
      tick();
      tick();
      test_reset();
      test_manual();
      test_auto_wrap();
      test_dwell();
      test_load_enable_range();
      test_masks();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised, registered N-channel, W-bit-wide multiplexer. Successor to the fixed 16:1 single-bit combinational mux.
- Two modes:
  - Manual select: the caller drives the channel index every cycle.
  - Auto-scan: an internal pointer steps through enabled channels, holding each for a programmable dwell time.
- Sits between a bank of sensor/data sources and a single downstream consumer. Output carries a registered channel tag and a valid flag.

Parameters:
- NUM_CH, 16, number of input channels; 2..256.
- DATA_W, 8, width of each channel in bits; >=1.
- SEL_W, 4, width of channel index; must satisfy 2**SEL_W >= NUM_CH.
- DWELL, 1, cycles each channel is held in auto mode; >=1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  advance/sample enable; when 0 all state holds.
- mode  input  1  0 = manual select, 1 = auto-scan.
- sel_in  input  SEL_W  manual channel index; auto-mode load value.
- load  input  1  auto mode only: jump pointer to sel_in.
- ch_mask  input  NUM_CH  1 = channel enabled.
- d  input  NUM_CH*DATA_W  packed inputs; channel k = d[k*DATA_W +: DATA_W].
- y  output  DATA_W  registered selected data.
- ch_out  output  SEL_W  index of the channel presented on y.
- valid  output  1  y holds data from an enabled, in-range channel.
- wrap  output  1  one-cycle pulse when the auto pointer wraps.

Behaviour:
- Reset, asynchronous, on rst=1:
  - Outputs: y=0, ch_out=0, valid=0, wrap=0.
  - Internal state: ptr=0, dwell_cnt=0.
- en=0: y, ch_out, valid, ptr and dwell_cnt hold; wrap forced to 0 on that edge.
- Output latency: one cycle. Values registered at edge t reflect inputs/ptr sampled at edge t.
- Manual mode (mode=0, en=1):
  - If sel_in < NUM_CH: y<=d[sel_in], ch_out<=sel_in, valid<=ch_mask[sel_in], ptr<=sel_in.
  - If sel_in >= NUM_CH: y<=0, ch_out<=sel_in, valid<=0; ptr unchanged.
  - dwell_cnt<=0, wrap<=0 throughout; load ignored.
- Auto mode (mode=1, en=1):
  - Output each cycle: y<=d[ptr], ch_out<=ptr, valid<=ch_mask[ptr].
  - Priority 1, load=1 with sel_in<NUM_CH: ptr<=sel_in, dwell_cnt<=0, wrap<=0.
  - Load with sel_in>=NUM_CH: ignored; fall through to priority 2.
  - Priority 2, dwell_cnt==DWELL-1: dwell_cnt<=0; ptr<=next(ptr).
  - next(ptr): lowest enabled index > ptr if one exists; else lowest enabled index overall (wrap). wrap<=1 iff a wrap occurred.
  - Otherwise: dwell_cnt<=dwell_cnt+1, wrap<=0.
- Single enabled channel: next(ptr) returns that channel. Wrap pulses once per DWELL cycles.
- ch_mask all zero: ptr holds, dwell_cnt still cycles, wrap=0. y/ch_out follow ptr; valid=0.
- Mask changes mid-scan: take effect at the next advance. The current channel keeps its remaining dwell, but valid reflects the live ch_mask[ptr].
- Mode change manual->auto: scan starts from the last in-range manual index with dwell_cnt=0.
- Mode change auto->manual: takes effect on the same edge.
- Reset asserted mid-scan: immediate return to reset values. Scan restarts at channel 0 after release.
- All selection logic is parametric (indexed part-select, loop search); no per-channel case lists.

Test Plan:
- Reset/manual mode. Stimulus: NUM_CH=16, DATA_W=8, d[k]=8'h10+k, mask=all 1, assert rst mid-run, then mode=0 and sweep sel_in 0..15. Required: y=0/valid=0 immediately on rst; after release, y=8'h10+sel_in one cycle later, ch_out tracks, valid=1.
- Auto scan wrap. Stimulus: DWELL=1, mask=16'h0005. Required: ch_out sequence 0,2,0,2…; wrap=1 on the edge ptr goes 2->0 only.
- Dwell. Stimulus: DWELL=3, mask=16'h0003. Required: ch_out = 0,0,0,1,1,1,0…; wrap once per 6 cycles.
- Load, enable and range. Stimulus: auto mode, load with sel_in=9 mid-dwell. Required: ch_out=9 for the next full DWELL cycles. Then en=0 for 4 cycles: all outputs frozen, wrap=0. Then manual sel_in=4'hF with NUM_CH=12: y=0, valid=0.
- Masks. Stimulus: mask=0 in auto. Required: valid=0, ch_out constant, wrap never pulses. Then mask=16'h8000: ch_out moves to 15 at next advance, wrap pulses each DWELL cycles.
